// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle for imem_fetch_ctrl.
// Groups the memory read port, the decode valid/ready handshake and the
// redirect/halt controls. The master modport is the fetch controller side;
// the slave modport is the environment (memory + decode + branch unit).
// Optional IMEM_FETCH_PERF_EN adds perf_fetches / perf_flushes.
interface imem_fetch_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_flushes;
`endif

  modport master (
    output mem_req, mem_addr, if_valid, if_instr, if_pc, halted,
`ifdef IMEM_FETCH_PERF_EN
    output perf_fetches, perf_flushes,
`endif
    input  mem_rdata, if_ready, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  mem_req, mem_addr, if_valid, if_instr, if_pc, halted,
`ifdef IMEM_FETCH_PERF_EN
    input  perf_fetches, perf_flushes,
`endif
    output mem_rdata, if_ready, redirect_valid, redirect_pc, halt_req
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller for a 1 KB little-endian instruction memory.
// Owns the PC, issues one word read per cycle to a 1-cycle-latency
// synchronous memory, buffers returned words in a QUEUE_DEPTH-entry queue
// and hands them to decode over valid/ready. Supports branch redirect
// (flushes queued and in-flight words via an epoch bit) and a halt/drain
// request.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - imem_fetch_ctrl_if.master: mem_req/mem_addr/mem_rdata,
//          if_valid/if_ready/if_instr/if_pc, redirect_valid/redirect_pc,
//          halt_req/halted
// Optional feature macro: IMEM_FETCH_PERF_EN adds saturating counters
//   perf_fetches (words pushed) and perf_flushes (redirect cycles).
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input logic              clk,
  input logic              rst,
  imem_fetch_ctrl_if.master bus
);

  localparam int unsigned PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t           state;
  logic [31:0]      pc;
  logic             epoch;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic             inflight_epoch;
  logic [31:0]      q_instr [QUEUE_DEPTH];
  logic [31:0]      q_pc    [QUEUE_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             q_nonempty;
  logic             pop;
  logic             push;
  logic             room;
  logic             issue;
  logic [CNT_W:0]   occ;
  logic [31:0]      push_word;

  always_comb begin
    q_nonempty = (count != '0);
    pop        = q_nonempty && bus.if_ready;
    // A redirect in the response cycle discards the returning word too.
    push       = inflight && (inflight_epoch == epoch) && !bus.redirect_valid;
    occ        = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    // A pop this cycle frees a slot in time for the next response, which
    // is what sustains one instruction per cycle with a 2-entry queue.
    room       = (occ < (CNT_W + 1)'(QUEUE_DEPTH)) || pop;
    issue      = !rst && !bus.halt_req && !bus.redirect_valid && room;
    push_word  = (inflight_pc >= MEM_LIMIT) ? NOP_INSTR : bus.mem_rdata;
  end

  assign bus.mem_req  = issue;
  assign bus.mem_addr = pc;
  assign bus.if_valid = q_nonempty;
  assign bus.if_instr = q_instr[head];
  assign bus.if_pc    = q_pc[head];
  assign bus.halted   = (state == S_HALTED);

  // PC, in-flight tag and instruction queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= pc;
        inflight_epoch <= epoch;
      end
      if (bus.redirect_valid) begin
        pc    <= bus.redirect_pc & ~32'h0000_0003;
        epoch <= ~epoch;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (issue) pc <= pc + 32'd4;
        if (push) begin
          q_instr[tail] <= push_word;
          q_pc[tail]    <= inflight_pc;
          tail          <= tail + PTR_W'(1);
        end
        if (pop) head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Run / drain / halted control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      case (state)
        S_RUN:    if (bus.halt_req) state <= S_DRAIN;
        S_DRAIN: begin
          if (!bus.halt_req)                  state <= S_RUN;
          else if (!q_nonempty && !inflight)  state <= S_HALTED;
        end
        S_HALTED: if (!bus.halt_req) state <= S_RUN;
        default:  state <= S_RUN;
      endcase
    end
  end

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetches_q;
  logic [31:0] perf_flushes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetches_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (push && (perf_fetches_q != '1))
        perf_fetches_q <= perf_fetches_q + 32'd1;
      if (bus.redirect_valid && (perf_flushes_q != '1))
        perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign bus.perf_fetches = perf_fetches_q;
  assign bus.perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a cycle table for the reset and
// back-pressure sequences, then hand-written redirect / out-of-range / halt
// / async-reset sequences checked through a delivery scoreboard.
module tb_imem_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if bus();

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(2),
    .MEM_BYTES  (1024),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Expected memory contents; out-of-range fetches must come back as NOP.
  function automatic logic [31:0] img(input logic [31:0] a);
    if (a >= 32'd1024) return 32'h0000_0013;
    case (a)
      32'h0:   return 32'h0010_0093;
      32'h4:   return 32'h0020_0113;
      32'h8:   return 32'h0020_81b3;
      32'hC:   return 32'h0000_0063;
      default: return 32'h5A00_0000 | a;
    endcase
  endfunction

  // Synchronous-read memory, 1-cycle latency; garbage above 1 KB.
  logic [31:0] mem [256];
  always @(posedge clk)
    if (bus.mem_req)
      bus.mem_rdata <= (bus.mem_addr < 32'd1024) ? mem[bus.mem_addr[9:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];
  bit   sb_on = 1'b0;

  task automatic expect_word(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = img(pc);
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (sb_on && bus.if_valid && bus.if_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliv_extra: got pc=%h, required no delivery", bus.if_pc);
      end else begin
        e = sb.pop_front();
        chk("deliv_pc", bus.if_pc, e.pc);
        chk("deliv_instr", bus.if_instr, e.instr);
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    to_neg();
    to_next();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.if_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    bus.if_ready = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt_req       = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          do_rst;
    bit          ready;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit r, input bit rdy, input bit req, input logic [31:0] addr,
                              input bit v, input logic [31:0] pc, input logic [31:0] ins);
    vec_t t;
    t.do_rst = r; t.ready = rdy; t.e_req = req; t.e_addr = addr;
    t.e_valid = v; t.e_pc = pc; t.e_instr = ins;
    vecs.push_back(t);
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = img(32'(i * 4));
    rst                = 1'b1;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt_req       = 1'b0;

    // Streaming from reset with decode always ready.
    add(1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0);
    add(1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0);
    add(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'h0010_0093);
    add(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 32'h0020_0113);
    add(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'h0020_81b3);
    add(1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 32'h0000_0063);
    // Decode stalls for 5 cycles at the first delivery.
    add(1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0);
    add(1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0, 32'h0010_0093);
    add(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'h0010_0093);
    add(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 32'h0020_0113);
    add(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'h0020_81b3);
    add(1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 32'h0000_0063);

    #2;
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      bus.if_ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), 32'(bus.mem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_if_valid", i), 32'(bus.if_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_if_pc", i), bus.if_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_if_instr", i), bus.if_instr, vecs[i].e_instr);
      end
      to_next();
    end
    bus.if_ready = 1'b0;

    // Redirect with a word queued (popped that cycle) and one in flight.
    do_reset();
    sb_on = 1'b1;
    bus.if_ready = 1'b1;
    expect_word(32'h0);
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0006;
    to_neg();
    chk("redir_no_issue", 32'(bus.mem_req), 32'h0);
    to_next();
    bus.redirect_valid = 1'b0;
    to_neg();
    chk("redir_flush_valid", 32'(bus.if_valid), 32'h0);
    chk("redir_mem_req", 32'(bus.mem_req), 32'h1);
    chk("redir_mem_addr", bus.mem_addr, 32'h4);
    to_next();
    expect_word(32'h4);
    expect_word(32'h8);
    expect_word(32'hC);
    drain(20);
    chk("redir_sb_empty", 32'(sb.size()), 32'h0);

    // Fetch across the top of memory.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_03FC;
    step();
    bus.redirect_valid = 1'b0;
    expect_word(32'h3FC);
    expect_word(32'h400);
    expect_word(32'h404);
    drain(20);

    // Halt with a full queue.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0020;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("halt_full_req", 32'(bus.mem_req), 32'h0);
      chk("halt_full_halted", 32'(bus.halted), 32'h0);
      chk("halt_full_valid", 32'(bus.if_valid), 32'h1);
      to_next();
    end
    expect_word(32'h20);
    expect_word(32'h24);
    drain(10);
    to_neg();
    chk("halt_gap_halted", 32'(bus.halted), 32'h0);
    chk("halt_gap_req", 32'(bus.mem_req), 32'h0);
    to_next();
    to_neg();
    chk("halted_set", 32'(bus.halted), 32'h1);
    chk("halted_req", 32'(bus.mem_req), 32'h0);
    to_next();
    bus.halt_req = 1'b0;
    to_neg();
    chk("resume_req", 32'(bus.mem_req), 32'h1);
    chk("resume_addr", bus.mem_addr, 32'h28);
    to_next();
    to_neg();
    chk("resume_halted", 32'(bus.halted), 32'h0);
    to_next();
    expect_word(32'h28);
    expect_word(32'h2C);
    drain(10);

`ifdef IMEM_FETCH_PERF_EN
    chk("perf_flushes_cnt", bus.perf_flushes, 32'd3);
`endif

    // Asynchronous reset between clock edges while streaming.
    sb_on = 1'b0;
    bus.if_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("arst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("arst_mem_addr", bus.mem_addr, 32'h0);
`ifdef IMEM_FETCH_PERF_EN
    chk("arst_perf_fetches", bus.perf_fetches, 32'h0);
    chk("arst_perf_flushes", bus.perf_flushes, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arst_rel_req", 32'(bus.mem_req), 32'h1);
    chk("arst_rel_addr", bus.mem_addr, 32'h0);
    chk("arst_rel_valid", 32'(bus.if_valid), 32'h0);
    to_next();
    sb_on = 1'b1;
    expect_word(32'h0);
    expect_word(32'h4);
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences instruction fetch from the byte-addressed, little-endian 1 KB instruction memory.
- Owns the PC and issues one word read per cycle to a synchronous-read memory port with 1-cycle latency.
- Buffers returned words in a small queue and hands them to decode over a valid/ready handshake.
- Supports branch redirect with flush of queued and in-flight words, and a halt/drain request.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, number of instruction queue entries (power of 2, minimum 2).
- MEM_BYTES, 1024, instruction memory size in bytes. Fetch addresses at or above this return NOP.
- NOP_INSTR, 32'h0000_0013, word substituted for out-of-range fetches (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  out  1  read request this cycle.
- mem_addr  out  32  word-aligned byte address. Bits [1:0] are always 0.
- mem_rdata  in  32  read data, valid the cycle after mem_req.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_ready  in  1  decode accepts the instruction this cycle.
- if_instr  out  32  instruction word.
- if_pc  out  32  address of if_instr.
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  new PC. Bits [1:0] are ignored (treated as 0).
- halt_req  in  1  level; stop issuing new fetches.
- halted  out  1  high when halted and the pipeline has drained.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, queue empty, in-flight flag cleared, epoch=0, state=RUN.
  - Outputs: mem_req=0, mem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0.
- Issue rule:
  - In RUN, mem_req=1 when (queue count + in-flight) < QUEUE_DEPTH and redirect_valid=0.
  - On issue: mem_addr=pc, pc<=pc+4. PC wraps modulo 2^32.
  - The in-flight tag records pc and the current epoch.
- Response:
  - The cycle after issue, the word is pushed to the queue with its pc, unless its epoch differs from the current epoch (discarded).
  - If the tagged pc is >= MEM_BYTES, NOP_INSTR is pushed instead of mem_rdata.
- Output handshake:
  - if_valid = queue non-empty; the head drives if_instr/if_pc.
  - Pop when if_valid && if_ready.
  - Simultaneous push and pop on a full queue is legal; count is unchanged.
  - Outputs are stable while if_valid=1 and if_ready=0.
- Fetch-to-decode latency:
  - First instruction after reset or redirect: if_valid asserts 2 cycles after the issue cycle (issue, memory, queue register).
  - Sustained throughput: 1 instruction/cycle with if_ready held high.
- Redirect (highest priority):
  - In the cycle redirect_valid=1: queue flushed (if_valid=0 next cycle), epoch toggles, pc<={redirect_pc[31:2],2'b00}, no issue that cycle.
  - Any pop in the same cycle is still honoured by decode; the flush takes effect after that cycle.
  - Redirect during HALTED loads pc but does not leave HALTED.
- FSM:
  - RUN -> DRAIN when halt_req=1. DRAIN: no issue; the in-flight response still completes; the queue keeps draining to decode.
  - DRAIN -> HALTED when the queue is empty and nothing is in flight. halted=1 only in HALTED.
  - DRAIN or HALTED -> RUN when halt_req=0. Issue resumes the same cycle.
- Reset mid-operation discards all state immediately, including the in-flight read.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- When defined, two extra outputs are present:
  - perf_fetches (32): count of words pushed to the queue.
  - perf_flushes (32): count of redirect cycles.
- Both reset to 0, saturate at 32'hFFFF_FFFF, and update the cycle after the event.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, if_ready=1, memory preloaded 0x00100093, 0x00200113, 0x002081b3, 0x00000063 at 0x0-0xC:
  - mem_addr 0x0,0x4,0x8,0xC on consecutive cycles.
  - if_valid rises at cycle 2.
  - if_pc 0x0,0x4,0x8,0xC back-to-back with matching if_instr.
- if_ready=0 for 5 cycles after the first delivery:
  - queue fills to 2, then mem_req=0.
  - if_instr/if_pc hold 0x00100093/0x0.
  - No word is lost or duplicated on release.
- redirect_valid=1, redirect_pc=0x00000006 while a fetch is in flight:
  - In-flight word discarded; if_valid=0 next cycle.
  - Next mem_addr=0x4; first if_pc after redirect=0x4.
- redirect_pc=0x000003FC, run 3 fetches:
  - if_pc 0x3FC gives memory data.
  - if_pc 0x400 and 0x404 give if_instr=0x00000013.
- halt_req=1 with queue full:
  - No new mem_req; halted=1 only after both entries are popped.
  - Deassert halt_req: fetch resumes at the next sequential pc.
- Assert rst asynchronously mid-stream (between edges):
  - if_valid=0 and mem_req=0 immediately.
  - After release, fetch restarts at RESET_PC.
  - With IMEM_FETCH_PERF_EN, counters read 0.
